// File: rtl/game_pkg.sv
// game_pkg: velocity fixed-point format shared by the game physics blocks.
// Velocities are signed, VELOCITY_INTEGER_WIDTH integer bits plus
// VELOCITY_FRACTION_WIDTH fraction bits.
package game_pkg;
    localparam int VELOCITY_INTEGER_WIDTH  = 6;
    localparam int VELOCITY_FRACTION_WIDTH = 4;
endpackage

// File: rtl/sram_pkg.sv
// sram_pkg: map and car coordinate widths shared with the map SRAM path.
// All coordinates are signed.
package sram_pkg;
    localparam int MAP_H_WIDTH    = 11;
    localparam int MAP_V_WIDTH    = 10;
    localparam int CAR_COOR_WIDTH = 6;
endpackage

// File: rtl/track_pkg.sv
// track_pkg: types shared by the track-collision scheduler.
//   sched_state_e        scheduler FSM states
//   car_track_operand_t  one car's operands for the TrackCollision datapath
//   car_track_result_t   one car's captured datapath result
package track_pkg;
    localparam int VW    = game_pkg::VELOCITY_INTEGER_WIDTH + game_pkg::VELOCITY_FRACTION_WIDTH;
    localparam int X_W   = sram_pkg::MAP_H_WIDTH;
    localparam int Y_W   = sram_pkg::MAP_V_WIDTH;
    localparam int R_W   = sram_pkg::CAR_COOR_WIDTH;
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } sched_state_e;

    typedef struct packed {
        logic signed [X_W-1:0] x;
        logic signed [Y_W-1:0] y;
        logic signed [VW-1:0]  v_x;
        logic signed [VW-1:0]  v_y;
        logic signed [R_W-1:0] radius;
    } car_track_operand_t;

    typedef struct packed {
        logic signed [VW-1:0] v_x;
        logic signed [VW-1:0] v_y;
        logic                 in_track0;
        logic                 in_track1;
        logic                 in_sand;
        logic                 in_rock;
        logic                 collision;
    } car_track_result_t;
endpackage

// File: rtl/sched_settle_counter.sv
// sched_settle_counter: loadable down-counter with a zero flag.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   load        load count with load_value (wins over dec)
//   load_value  value to load
//   dec         decrement by one, holding at zero
//   zero        count is zero
module sched_settle_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (dec && count != '0)
            count <= count - WIDTH'(1);
    end

    assign zero = (count == '0);
endmodule

// File: rtl/track_collision_scheduler.sv
// track_collision_scheduler: shares one TrackCollision datapath between
// N_CAR cars once per frame. On i_start every car's operands are snapshot,
// then each car is driven to the datapath in index order, allowed to settle
// for SETTLE_CYCLES cycles, and its result captured into per-car registers.
// Optional feature macro COLLISION_COUNT_EN adds i_clear and per-car
// saturating collision-frame counters o_coll_cnt.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_start                frame-start pulse (ignored and flagged when busy)
//   i_x/i_y/i_v_x/i_v_y/i_radius [N_CAR]  per-car operands
//   o_trk_*                registered operands to the datapath
//   i_trk_*                datapath velocity and flags
//   o_v_x/o_v_y/o_in_*/o_collision [N_CAR]  captured per-car results
//   o_busy, o_done, o_overrun  sweep status
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for i_start; o_trk_* hold last operands
// ST_DRIVE   | load o_trk_* from shadow[idx], load settle count
// ST_SETTLE  | wait for the datapath to settle
// ST_CAPTURE | register datapath result into result[idx]
// ST_DONE    | one-cycle o_done, back to idle
module track_collision_scheduler
    import track_pkg::*;
#(
    parameter int N_CAR         = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
`ifdef COLLISION_COUNT_EN
    input  logic                  i_clear,
`endif
    input  logic signed [X_W-1:0] i_x      [N_CAR],
    input  logic signed [Y_W-1:0] i_y      [N_CAR],
    input  logic signed [VW-1:0]  i_v_x    [N_CAR],
    input  logic signed [VW-1:0]  i_v_y    [N_CAR],
    input  logic signed [R_W-1:0] i_radius [N_CAR],
    output logic signed [X_W-1:0] o_trk_x,
    output logic signed [Y_W-1:0] o_trk_y,
    output logic signed [VW-1:0]  o_trk_v_x,
    output logic signed [VW-1:0]  o_trk_v_y,
    output logic signed [R_W-1:0] o_trk_radius,
    input  logic signed [VW-1:0]  i_trk_v_x,
    input  logic signed [VW-1:0]  i_trk_v_y,
    input  logic                  i_trk_in_track0,
    input  logic                  i_trk_in_track1,
    input  logic                  i_trk_in_sand,
    input  logic                  i_trk_in_rock,
    input  logic                  i_trk_collision,
    output logic signed [VW-1:0]  o_v_x       [N_CAR],
    output logic signed [VW-1:0]  o_v_y       [N_CAR],
    output logic                  o_in_track0 [N_CAR],
    output logic                  o_in_track1 [N_CAR],
    output logic                  o_in_sand   [N_CAR],
    output logic                  o_in_rock   [N_CAR],
    output logic                  o_collision [N_CAR],
`ifdef COLLISION_COUNT_EN
    output logic [7:0]            o_coll_cnt  [N_CAR],
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overrun
);
    localparam int               IDX_W    = (N_CAR > 1) ? $clog2(N_CAR) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAR - 1);

    sched_state_e       state, state_next;
    logic [IDX_W-1:0]   idx;
    car_track_operand_t shadow [N_CAR];
    car_track_operand_t trk;
    car_track_result_t  result [N_CAR];
    logic               snapshot, drive, capture, settle_zero;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        snapshot   = 1'b0;
        drive      = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    snapshot   = 1'b1;
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                drive      = 1'b1;
                state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_zero)
                    state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture    = 1'b1;
                state_next = (idx == LAST_IDX) ? ST_DONE : ST_DRIVE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Loaded with SETTLE_CYCLES-1 so that SETTLE lasts SETTLE_CYCLES cycles.
    sched_settle_counter #(.WIDTH(CNT_W)) u_settle (
        .clk        (i_clk),
        .rst        (i_rst),
        .load       (drive),
        .load_value (CNT_W'(SETTLE_CYCLES - 1)),
        .dec        (state == ST_SETTLE),
        .zero       (settle_zero)
    );

    // Shadow copy only feeds trk, which is reset, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (snapshot) begin
            for (int k = 0; k < N_CAR; k++)
                shadow[k] <= '{x: i_x[k], y: i_y[k], v_x: i_v_x[k],
                               v_y: i_v_y[k], radius: i_radius[k]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx       <= '0;
            trk       <= '0;
            o_overrun <= 1'b0;
            for (int k = 0; k < N_CAR; k++)
                result[k] <= '0;
        end else begin
            if (snapshot)
                idx <= '0;
            if (drive)
                trk <= shadow[idx];
            if (capture) begin
                result[idx] <= '{v_x: i_trk_v_x, v_y: i_trk_v_y,
                                 in_track0: i_trk_in_track0, in_track1: i_trk_in_track1,
                                 in_sand: i_trk_in_sand, in_rock: i_trk_in_rock,
                                 collision: i_trk_collision};
                if (idx != LAST_IDX)
                    idx <= idx + IDX_W'(1);
            end
            if (i_start && state != ST_IDLE)
                o_overrun <= 1'b1;
        end
    end

`ifdef COLLISION_COUNT_EN
    logic [7:0] coll_cnt [N_CAR];

    // Clear beats a same-cycle increment.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            for (int k = 0; k < N_CAR; k++)
                coll_cnt[k] <= '0;
        end else if (capture && i_trk_collision && coll_cnt[idx] != 8'hFF) begin
            coll_cnt[idx] <= coll_cnt[idx] + 8'd1;
        end
    end

    assign o_coll_cnt = coll_cnt;
`endif

    assign o_trk_x      = trk.x;
    assign o_trk_y      = trk.y;
    assign o_trk_v_x    = trk.v_x;
    assign o_trk_v_y    = trk.v_y;
    assign o_trk_radius = trk.radius;
    assign o_busy       = (state != ST_IDLE);
    assign o_done       = (state == ST_DONE);

    for (genvar k = 0; k < N_CAR; k++) begin : g_out
        assign o_v_x[k]       = result[k].v_x;
        assign o_v_y[k]       = result[k].v_y;
        assign o_in_track0[k] = result[k].in_track0;
        assign o_in_track1[k] = result[k].in_track1;
        assign o_in_sand[k]   = result[k].in_sand;
        assign o_in_rock[k]   = result[k].in_rock;
        assign o_collision[k] = result[k].collision;
    end
endmodule

// File: tb/tb_track_collision_scheduler.sv
module tb_track_collision_scheduler;
    import track_pkg::*;

    localparam int N     = 2;
    localparam int S     = 2;
    localparam int PER   = S + 2;
    localparam int SWEEP = N * PER + 1;

    logic clk = 1'b0;
    logic rst, start, clear;
    logic signed [X_W-1:0] x   [N];
    logic signed [Y_W-1:0] y   [N];
    logic signed [VW-1:0]  vx  [N];
    logic signed [VW-1:0]  vy  [N];
    logic signed [R_W-1:0] rad [N];

    logic signed [X_W-1:0] o_trk_x;
    logic signed [Y_W-1:0] o_trk_y;
    logic signed [VW-1:0]  o_trk_v_x, o_trk_v_y;
    logic signed [R_W-1:0] o_trk_radius;
    logic signed [VW-1:0]  o_v_x [N];
    logic signed [VW-1:0]  o_v_y [N];
    logic o_in_track0 [N], o_in_track1 [N], o_in_sand [N], o_in_rock [N], o_collision [N];
    logic [7:0] o_coll_cnt [N];
    logic o_busy, o_done, o_overrun;

    car_track_operand_t trk_op;
    car_track_result_t  trk_res;

    always #5 clk = ~clk;

    // Stand-in for the TrackCollision datapath: anything left of x=-500 is a wall.
    function automatic car_track_result_t dp(input car_track_operand_t op);
        car_track_result_t r;
        int xi, yi, ri;
        bit c;
        xi = $signed(op.x);
        yi = $signed(op.y);
        ri = $signed(op.radius);
        c  = (xi < -500);
        r.v_x       = c ? '0 : op.v_x;
        r.v_y       = c ? '0 : op.v_y;
        r.in_track0 = !c && (yi < 0);
        r.in_track1 = !c && xi[0];
        r.in_sand   = (xi > 300);
        r.in_rock   = (ri > 20);
        r.collision = c;
        return r;
    endfunction

    always_comb begin
        trk_op  = '{x: o_trk_x, y: o_trk_y, v_x: o_trk_v_x, v_y: o_trk_v_y, radius: o_trk_radius};
        trk_res = dp(trk_op);
    end

    track_collision_scheduler #(.N_CAR(N), .SETTLE_CYCLES(S)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
`ifdef COLLISION_COUNT_EN
        .i_clear         (clear),
`endif
        .i_x             (x),
        .i_y             (y),
        .i_v_x           (vx),
        .i_v_y           (vy),
        .i_radius        (rad),
        .o_trk_x         (o_trk_x),
        .o_trk_y         (o_trk_y),
        .o_trk_v_x       (o_trk_v_x),
        .o_trk_v_y       (o_trk_v_y),
        .o_trk_radius    (o_trk_radius),
        .i_trk_v_x       (trk_res.v_x),
        .i_trk_v_y       (trk_res.v_y),
        .i_trk_in_track0 (trk_res.in_track0),
        .i_trk_in_track1 (trk_res.in_track1),
        .i_trk_in_sand   (trk_res.in_sand),
        .i_trk_in_rock   (trk_res.in_rock),
        .i_trk_collision (trk_res.collision),
        .o_v_x           (o_v_x),
        .o_v_y           (o_v_y),
        .o_in_track0     (o_in_track0),
        .o_in_track1     (o_in_track1),
        .o_in_sand       (o_in_sand),
        .o_in_rock       (o_in_rock),
        .o_collision     (o_collision),
`ifdef COLLISION_COUNT_EN
        .o_coll_cnt      (o_coll_cnt),
`endif
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_overrun       (o_overrun)
    );

`ifndef COLLISION_COUNT_EN
    initial for (int k = 0; k < N; k++) o_coll_cnt[k] = '0;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: per-sweep schedule from the accepting edge.
    // Cycle c=1 is the first busy cycle; car k is on o_trk_* from c=k*PER+2,
    // its result is visible from c=(k+1)*PER+1, done is at c=SWEEP.
    bit                 model_ok = 0;
    bit                 active   = 0;
    int                 t0       = 0;
    bit                 exp_busy = 0, exp_done = 0, exp_ovr = 0;
    car_track_operand_t snap [N];
    car_track_operand_t exp_trk;
    car_track_result_t  exp_res [N];
    int                 exp_cnt [N];

    always @(posedge clk) begin
        int c;
        cyc++;
        if (rst) begin
            model_ok = 1;
            active   = 0;
            exp_busy = 0;
            exp_done = 0;
            exp_ovr  = 0;
            exp_trk  = '0;
            for (int k = 0; k < N; k++) begin
                exp_res[k] = '0;
                exp_cnt[k] = 0;
            end
        end else begin
            if (start) begin
                if (exp_busy) exp_ovr = 1;
                else begin
                    active = 1;
                    t0     = cyc;
                    for (int k = 0; k < N; k++)
                        snap[k] = '{x: x[k], y: y[k], v_x: vx[k], v_y: vy[k], radius: rad[k]};
                end
            end
`ifdef COLLISION_COUNT_EN
            if (clear) for (int k = 0; k < N; k++) exp_cnt[k] = 0;
`endif
            exp_busy = 0;
            exp_done = 0;
            if (active) begin
                c        = cyc - t0 + 1;
                exp_busy = (c <= SWEEP);
                exp_done = (c == SWEEP);
                for (int k = 0; k < N; k++) begin
                    if (c == k * PER + 2) exp_trk = snap[k];
                    if (c == (k + 1) * PER + 1) begin
                        exp_res[k] = dp(snap[k]);
`ifdef COLLISION_COUNT_EN
                        if (!clear && exp_res[k].collision && exp_cnt[k] < 255) exp_cnt[k]++;
`endif
                    end
                end
                if (c >= SWEEP) active = 0;
            end
        end
    end

    int done_q[$];

    always @(negedge clk) begin
        if (model_ok) begin
            if (o_done) done_q.push_back(cyc);
            chk("busy", o_busy, exp_busy);
            chk("done", o_done, exp_done);
            chk("overrun", o_overrun, exp_ovr);
            chk("trk_x", $signed(o_trk_x), $signed(exp_trk.x));
            chk("trk_y", $signed(o_trk_y), $signed(exp_trk.y));
            chk("trk_v_x", $signed(o_trk_v_x), $signed(exp_trk.v_x));
            chk("trk_v_y", $signed(o_trk_v_y), $signed(exp_trk.v_y));
            chk("trk_radius", $signed(o_trk_radius), $signed(exp_trk.radius));
            for (int k = 0; k < N; k++) begin
                chk("res_v_x", $signed(o_v_x[k]), $signed(exp_res[k].v_x));
                chk("res_v_y", $signed(o_v_y[k]), $signed(exp_res[k].v_y));
                chk("res_flags",
                    {o_in_track0[k], o_in_track1[k], o_in_sand[k], o_in_rock[k], o_collision[k]},
                    {exp_res[k].in_track0, exp_res[k].in_track1, exp_res[k].in_sand,
                     exp_res[k].in_rock, exp_res[k].collision});
`ifdef COLLISION_COUNT_EN
                chk("coll_cnt", o_coll_cnt[k], exp_cnt[k]);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start pulse from the current cycle; returns cyc of cycle 1.
    task automatic kick(output int s);
        start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
    endtask

    task automatic goto_cycle(input int s, input int c);
        while (cyc < s + c - 1) tick();
    endtask

    int s;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        x[0] = 0;    y[0] = -300; vx[0] = 5; vy[0] = 3;  rad[0] = 10;
        x[1] = -560; y[1] = -250; vx[1] = 0; vy[1] = -4; rad[1] = 25;
        repeat (3) tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_trk_y", $signed(o_trk_y), 0);
        rst = 1'b0;
        tick();

        // Single sweep
        done_q = {};
        kick(s);
        goto_cycle(s, 9);
        chk("t1_done_c9", o_done, 1);
        goto_cycle(s, 11);
        chk("t1_done_count", done_q.size(), 1);
        chk("t1_done_cycle", (done_q.size() > 0) ? done_q[0] - s + 1 : -1, 9);
        chk("t1_car0_vx", $signed(o_v_x[0]), 5);
        chk("t1_car0_vy", $signed(o_v_y[0]), 3);
        chk("t1_car0_coll", o_collision[0], 0);
        chk("t1_car1_vx", $signed(o_v_x[1]), 0);
        chk("t1_car1_vy", $signed(o_v_y[1]), 0);
        chk("t1_car1_coll", o_collision[1], 1);

        // Snapshot isolation
        kick(s);
        goto_cycle(s, 2);
        x[0] = 400;
        goto_cycle(s, 3);
        chk("t2_trk_x", $signed(o_trk_x), 0);
        goto_cycle(s, 11);
        chk("t2_car0_sand", o_in_sand[0], 0);
        x[0] = 0;

        // Overrun
        done_q = {};
        kick(s);
        goto_cycle(s, 4);
        kick(s);
        s = s - 4;
        chk("t3_ovr_c5", o_overrun, 1);
        goto_cycle(s, 12);
        chk("t3_done_count", done_q.size(), 1);
        chk("t3_done_cycle", (done_q.size() > 0) ? done_q[0] - s + 1 : -1, 9);
        chk("t3_ovr_sticky", o_overrun, 1);

        // Reset mid-sweep
        done_q = {};
        kick(s);
        goto_cycle(s, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_busy", o_busy, 0);
        chk("t4_car0_vx", $signed(o_v_x[0]), 0);
        chk("t4_ovr", o_overrun, 0);
        goto_cycle(s, 14);
        chk("t4_no_done", done_q.size(), 0);
        kick(s);
        goto_cycle(s, 11);
        chk("t4_restart_done", done_q.size(), 1);
        chk("t4_restart_car0_vx", $signed(o_v_x[0]), 5);

        // Back-to-back
        done_q = {};
        kick(s);
        goto_cycle(s, 10);
        start = 1'b1;
        tick();
        start = 1'b0;
        goto_cycle(s, 21);
        chk("t5_done_count", done_q.size(), 2);
        chk("t5_done0", (done_q.size() > 0) ? done_q[0] - s + 1 : -1, 9);
        chk("t5_done1", (done_q.size() > 1) ? done_q[1] - s + 1 : -1, 19);
        chk("t5_ovr", o_overrun, 0);

`ifdef COLLISION_COUNT_EN
        // Saturating collision counter, then clear against a capture
        for (int i = 0; i < 300; i++) begin
            kick(s);
            goto_cycle(s, 10);
        end
        goto_cycle(s, 12);
        chk("t6_cnt1_sat", o_coll_cnt[1], 255);
        chk("t6_cnt0", o_coll_cnt[0], 0);
        kick(s);
        goto_cycle(s, 8);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t6_clear_wins", o_coll_cnt[1], 0);
        goto_cycle(s, 11);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
